// File: rtl/cla_arb_pkg.sv
// Shared types and helpers for the round-robin arbitrated carry-lookahead adder.
package cla_arb_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} cla_arb_state_t;

  // Requester-ID width; never zero, even for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Unsigned WIDTH-bit carry-lookahead adder; sum_o carries the carry-out in its MSB.
module carry_lookahead_adder #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   sum_o
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // NOTE: combinational blocks use blocking '=' so each carry sees the one
  // computed just before it; carry[0] is assigned first so no latch is inferred.
  always_comb begin
    carry[0] = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  assign sum_o = {carry[WIDTH], prop ^ carry[WIDTH-1:0]};

endmodule

// File: rtl/cla_adder_arbiter.sv
// Round-robin arbiter sharing one carry_lookahead_adder among NUM_REQ requesters.
// Optional sticky adder self-check is built when CLA_ARB_SELFCHECK_EN is defined.
module cla_adder_arbiter
  import cla_arb_pkg::*;
#(
  parameter  int WIDTH   = 3,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic                     o_rsp_valid,
  output logic [WIDTH:0]           o_rsp_sum,
  output logic [ID_W-1:0]          o_rsp_id,
  input  logic                     i_rsp_ready,
  output logic                     o_err
);

  cla_arb_state_t   state_q;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [ID_W-1:0]  id_q;
  logic             rsp_valid_q;
  logic [WIDTH:0]   rsp_sum_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic [WIDTH:0]   adder_sum;
  logic             pick_hit;
  logic [ID_W-1:0]  pick_id;
  logic             accept;

  // First asserted valid at or above ptr, wrapping past NUM_REQ-1; returns {hit, id}.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    int              idx;
    logic            hit;
    logic [ID_W-1:0] win;
    hit = 1'b0;
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!hit && valid[idx]) begin
        hit = 1'b1;
        win = ID_W'(idx);
      end
    end
    return {hit, win};
  endfunction

  assign {pick_hit, pick_id} = rr_pick(i_req_valid, rr_ptr_q);
  assign accept   = (state_q == IDLE) && pick_hit;
  assign rr_ptr_d = (pick_id == ID_W'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;

  // Grant is suppressed while reset is held so no requester sees a false accept.
  assign o_req_ready = (accept && i_rst_n) ? (NUM_REQ'(1) << pick_id) : '0;

  carry_lookahead_adder #(.WIDTH(WIDTH)) u_adder (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (adder_sum)
  );

`ifdef CLA_ARB_SELFCHECK_EN
  logic err_q;
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values; the operand registers are few enough to reset explicitly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_id_q    <= '0;
`ifdef CLA_ARB_SELFCHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q      <= i_req_a[pick_id*WIDTH +: WIDTH];
            b_q      <= i_req_b[pick_id*WIDTH +: WIDTH];
            id_q     <= pick_id;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_sum_q   <= adder_sum;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
`ifdef CLA_ARB_SELFCHECK_EN
          if (adder_sum != ({1'b0, a_q} + {1'b0, b_q})) err_q <= 1'b1;
`endif
        end
        RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_sum   = rsp_sum_q;
  assign o_rsp_id    = rsp_id_q;

endmodule
